// File: rtl/rs_cmd_sequencer.sv
// rs_cmd_sequencer: upstream command stage for an RS flip-flop.
// Debounces raw set/clear request lines, turns each debounced rising edge
// into one registered S or R pulse (never both), then checks the flip-flop's
// q/qbar feedback against the expected state and raises a sticky error.

// rs_cmd_debounce: one request channel (synchroniser + debounce counter).
// Emits a one-cycle 'rise' on the edge where the stable value flips 0->1.
module rs_cmd_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // Stable value flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample
    assign flip = (s2 != stable) && (cnt == CNT_MAX);
    assign rise = flip && s2;

    // Two-flop synchroniser for the raw asynchronous request line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Debounce counter: any agreement with the stable value restarts the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (flip) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

module rs_cmd_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4,
    parameter int SET_PRIORITY    = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic set_req,
    input  logic clr_req,
    input  logic err_clr,
    input  logic q_fb,
    input  logic qbar_fb,
    output logic S,
    output logic R,
    output logic busy,
    output logic exp_q,
    output logic err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    logic [1:0] state;
    logic       set_rise;
    logic       clr_rise;
    logic       set_pend;
    logic       clr_pend;
    logic       serve_set;
    logic       serve_clr;
    logic       mismatch;

    rs_cmd_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_set_deb (
        .clk  (clk),
        .reset(reset),
        .din  (set_req),
        .rise (set_rise)
    );

    rs_cmd_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_clr_deb (
        .clk  (clk),
        .reset(reset),
        .din  (clr_req),
        .rise (clr_rise)
    );

    assign busy     = (state != ST_IDLE);
    assign mismatch = (q_fb != exp_q) | (q_fb == qbar_fb);

    // Pick which pending request (if any) is launched from IDLE this cycle
    always_comb begin
        serve_set = 1'b0;
        serve_clr = 1'b0;
        if (state == ST_IDLE) begin
            if (set_pend && clr_pend) begin
                if (SET_PRIORITY != 0) begin
                    serve_set = 1'b1;
                end else begin
                    serve_clr = 1'b1;
                end
            end else if (set_pend) begin
                serve_set = 1'b1;
            end else if (clr_pend) begin
                serve_clr = 1'b1;
            end
        end
    end

    // Single-depth request flags; a fresh rising edge outranks a same-cycle launch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            set_pend <= 1'b0;
            clr_pend <= 1'b0;
        end else begin
            if (set_rise) begin
                set_pend <= 1'b1;
            end else if (serve_set) begin
                set_pend <= 1'b0;
            end
            if (clr_rise) begin
                clr_pend <= 1'b1;
            end else if (serve_clr) begin
                clr_pend <= 1'b0;
            end
        end
    end

    // IDLE -> DRIVE (one-cycle pulse) -> CHECK (feedback sample) -> IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            S     <= 1'b0;
            R     <= 1'b0;
            exp_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (serve_set) begin
                        S     <= 1'b1;
                        exp_q <= 1'b1;
                        state <= ST_DRIVE;
                    end else if (serve_clr) begin
                        R     <= 1'b1;
                        exp_q <= 1'b0;
                        state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    S     <= 1'b0;
                    R     <= 1'b0;
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    S     <= 1'b0;
                    R     <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky feedback error; a mismatch in CHECK beats a coincident err_clr
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if ((state == ST_CHECK) && mismatch) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rs_cmd_sequencer.sv
// Testbench for rs_cmd_sequencer: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the request/pulse rules
// and a behavioural RS flip-flop that supplies the q/qbar feedback.
module tb_rs_cmd_sequencer;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic reset;
    logic set_req;
    logic clr_req;
    logic err_clr;
    logic q_fb;
    logic qbar_fb;
    logic S;
    logic R;
    logic busy;
    logic exp_q;
    logic err;

    int errors = 0;
    int checks = 0;

    // Feedback source: 0 = real flip-flop, 1 = stuck q=0/qbar=1, 2 = q=qbar=1
    int fb_mode = 0;
    bit ff_q = 1'b0;

    // Reference model state
    bit set_hist[$];
    bit clr_hist[$];
    bit m_set_stable, m_clr_stable;
    bit m_set_pend, m_clr_pend;
    bit m_S, m_R, m_exp, m_err;
    int m_busy_left;

    rs_cmd_sequencer #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (4),
        .SET_PRIORITY   (0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .set_req(set_req),
        .clr_req(clr_req),
        .err_clr(err_clr),
        .q_fb   (q_fb),
        .qbar_fb(qbar_fb),
        .S      (S),
        .R      (R),
        .busy   (busy),
        .exp_q  (exp_q),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        set_hist.delete();
        clr_hist.delete();
        repeat (DC + 3) begin
            set_hist.push_back(1'b0);
            clr_hist.push_back(1'b0);
        end
        m_set_stable = 0; m_clr_stable = 0;
        m_set_pend = 0;   m_clr_pend = 0;
        m_S = 0; m_R = 0; m_exp = 0; m_err = 0;
        m_busy_left = 0;
    endtask

    // A line is accepted once the raw value, seen two edges late, has
    // disagreed with the accepted value on DC consecutive edges.
    function automatic bit accepts(input bit h[$], input bit stable);
        for (int i = 0; i < DC; i++) begin
            if (h[h.size() - 3 - i] == stable) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step(input bit si, input bit ci, input bit ei, input bit qi, input bit qbi);
        bit set_flip, clr_flip, set_rise, clr_rise, go_set, go_clr;
        set_hist.push_back(si);
        clr_hist.push_back(ci);
        if (set_hist.size() > DC + 3) void'(set_hist.pop_front());
        if (clr_hist.size() > DC + 3) void'(clr_hist.pop_front());
        set_flip = accepts(set_hist, m_set_stable);
        clr_flip = accepts(clr_hist, m_clr_stable);
        set_rise = set_flip && !m_set_stable;
        clr_rise = clr_flip && !m_clr_stable;
        go_set = 0;
        go_clr = 0;
        if (m_busy_left == 0) begin
            if (m_clr_pend) go_clr = 1;
            else if (m_set_pend) go_set = 1;
        end
        if (m_busy_left == 1 && (qi != m_exp || qi == qbi)) m_err = 1;
        else if (ei) m_err = 0;
        m_S = go_set;
        m_R = go_clr;
        if (go_set) m_exp = 1;
        else if (go_clr) m_exp = 0;
        if (go_set || go_clr) m_busy_left = 2;
        else if (m_busy_left > 0) m_busy_left--;
        if (set_flip) m_set_stable = !m_set_stable;
        if (clr_flip) m_clr_stable = !m_clr_stable;
        if (set_rise) m_set_pend = 1; else if (go_set) m_set_pend = 0;
        if (clr_rise) m_clr_pend = 1; else if (go_clr) m_clr_pend = 0;
    endtask

    task automatic drive_fb();
        case (fb_mode)
            1: begin q_fb = 1'b0; qbar_fb = 1'b1; end
            2: begin q_fb = 1'b1; qbar_fb = 1'b1; end
            default: begin q_fb = ff_q; qbar_fb = !ff_q; end
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".S"}, S, m_S);
        chk({tag, ".R"}, R, m_R);
        chk({tag, ".busy"}, busy, m_busy_left != 0);
        chk({tag, ".exp_q"}, exp_q, m_exp);
        chk({tag, ".err"}, err, m_err);
        chk({tag, ".s_and_r"}, S & R, 1'b0);
    endtask

    task automatic tick(input string tag);
        bit si, ci, ei, qi, qbi, ps, pr;
        si = set_req; ci = clr_req; ei = err_clr; qi = q_fb; qbi = qbar_fb;
        ps = m_S; pr = m_R;
        @(posedge clk);
        model_step(si, ci, ei, qi, qbi);
        if (ps) ff_q = 1'b1;
        else if (pr) ff_q = 1'b0;
        #1;
        drive_fb();
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_req = 1'b0; clr_req = 1'b0; err_clr = 1'b0;
        fb_mode = 0;
        ff_q = 1'b0;
        model_reset();
        drive_fb();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;
    endtask

    task automatic settle(input string tag);
        repeat (10) tick(tag);
    endtask

    initial begin
        int r_edge, s_edge, s_count, set_hold, clr_hold;

        // 1: held set request -> one S pulse from edge DC+3, good feedback
        do_reset();
        set_req = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick("t1");
            chk("t1_s_edge", S, e == DC + 3);
        end
        chk("t1_exp_q", exp_q, 1'b1);
        chk("t1_err", err, 1'b0);
        set_req = 1'b0;
        settle("t1_settle");

        // 2: 3-cycle glitch is discarded
        set_req = 1'b1;
        repeat (3) tick("t2");
        set_req = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick("t2");
            chk("t2_no_s", S, 1'b0);
            chk("t2_idle", busy, 1'b0);
        end

        // 3: simultaneous requests, clear served first, set 3 cycles later
        set_req = 1'b1;
        clr_req = 1'b1;
        r_edge = -1; s_edge = -1;
        for (int e = 1; e <= 14; e++) begin
            tick("t3");
            if (R) r_edge = e;
            if (S) s_edge = e;
        end
        chk("t3_r_first", r_edge == DC + 3, 1'b1);
        chk("t3_s_spacing", s_edge - r_edge == 3, 1'b1);
        chk("t3_final_exp_q", exp_q, 1'b1);
        set_req = 1'b0; clr_req = 1'b0;
        settle("t3_settle");

        // 4: bad feedback -> sticky err at edge DC+5, cleared by err_clr
        fb_mode = 1; drive_fb();
        set_req = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick("t4");
            chk("t4_err_edge", err, e >= DC + 5);
        end
        set_req = 1'b0; fb_mode = 0; drive_fb();
        settle("t4_settle");
        clr_req = 1'b1;
        settle("t4_good_clr");
        clr_req = 1'b0;
        settle("t4_settle2");
        chk("t4_err_sticky", err, 1'b1);
        err_clr = 1'b1;
        tick("t4_errclr");
        err_clr = 1'b0;
        chk("t4_err_cleared", err, 1'b0);
        fb_mode = 2; drive_fb();
        set_req = 1'b1;
        settle("t4_both_hi");
        chk("t4_err_both_hi", err, 1'b1);
        set_req = 1'b0; fb_mode = 0; drive_fb();
        settle("t4_settle3");
        err_clr = 1'b1;
        tick("t4_errclr2");
        err_clr = 1'b0;

        // 5: asynchronous reset while S is high
        set_req = 1'b1;
        repeat (DC + 3) tick("t5");
        chk("t5_s_high", S, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_async_s", S, 1'b0);
        chk("t5_async_busy", busy, 1'b0);
        chk("t5_async_exp_q", exp_q, 1'b0);
        set_req = 1'b0;
        ff_q = 1'b0;
        model_reset();
        drive_fb();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_all("t5_after");
        for (int e = 0; e < 12; e++) begin
            tick("t5_no_pend");
            chk("t5_no_pulse", S | R, 1'b0);
        end

        // 6: set arriving as clear's CHECK ends; raw set toggles coalesce
        clr_req = 1'b1;
        repeat (3) tick("t6");
        set_req = 1'b1;
        s_edge = -1;
        for (int e = 4; e <= 14; e++) begin
            tick("t6");
            if (S && s_edge < 0) s_edge = e;
        end
        chk("t6_s_after_check", s_edge == DC + 6, 1'b1);
        set_req = 1'b0; clr_req = 1'b0;
        settle("t6_settle");
        clr_req = 1'b1;
        s_count = 0;
        for (int e = 0; e < 5; e++) begin
            set_req = 1'(e % 2 == 0);
            tick("t6b");
            s_count += int'(S);
        end
        set_req = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick("t6b");
            s_count += int'(S);
        end
        chk("t6_one_s_pulse", s_count == 1, 1'b1);
        set_req = 1'b0; clr_req = 1'b0;
        settle("t6_settle2");

        // Randomized traffic against the model
        set_hold = 0; clr_hold = 0;
        for (int c = 0; c < 800; c++) begin
            if (set_hold == 0) begin
                set_req = 1'($urandom_range(0, 1));
                set_hold = $urandom_range(1, 10);
            end else begin
                set_hold--;
            end
            if (clr_hold == 0) begin
                clr_req = 1'($urandom_range(0, 1));
                clr_hold = $urandom_range(1, 10);
            end else begin
                clr_hold--;
            end
            err_clr = 1'($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) begin
                fb_mode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                drive_fb();
            end
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
